// File: rtl/line_buffer_param.sv
// line_buffer_param: DEPTH-row shift-register line buffer feeding the window
// stages. Tracks how many real rows are loaded, raises window_valid once the
// window is full, and on drain_req pads the bottom border with HALO rows.
// Optional build macro LB_BORDER_REPLICATE_EN: drain pads with copies of the
// newest row instead of zeros (zeros still used when no real row was loaded).
module line_buffer_param #(
    parameter int         ROW_W       = 5120,
    parameter int         DEPTH       = 10,
    parameter int         HALO        = 5,
    parameter logic [2:0] ACTIVE_MODE = 3'd1,
    parameter int         CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             buffer_mode,
    input  logic                   buffer_we,
    input  logic [ROW_W-1:0]       img_data,
    input  logic                   drain_req,
    output logic [DEPTH*ROW_W-1:0] buf_data,
    output logic [CNT_W-1:0]       fill_cnt,
    output logic                   window_valid,
    output logic                   busy
);

    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("line_buffer_param: DEPTH=%0d outside 2..16", DEPTH);
    end
    if (HALO < 1 || HALO > DEPTH) begin : g_bad_halo
        $error("line_buffer_param: HALO=%0d outside 1..DEPTH", HALO);
    end

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

    state_t                        state_q, state_d;
    logic [DEPTH-1:0][ROW_W-1:0]   rows_q, rows_d;
    logic [CNT_W-1:0]              fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0]              drain_cnt_q, drain_cnt_d;
    logic                          window_valid_q, window_valid_d;
    logic                          busy_q, busy_d;
    logic                          mode_on;
    logic                          fill_last;
    logic                          drain_last;
    logic [ROW_W-1:0]              pad_row;

    assign mode_on    = (buffer_mode == ACTIVE_MODE);
    assign fill_last  = (fill_cnt_q == CNT_W'(DEPTH - 1));
    assign drain_last = (drain_cnt_q == CNT_W'(HALO - 1));

`ifdef LB_BORDER_REPLICATE_EN
    // Edge replication only makes sense once a real row sits in row 0.
    assign pad_row = (fill_cnt_q == '0) ? '0 : rows_q[0];
`else
    assign pad_row = '0;
`endif

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rows_q         <= '0;
            fill_cnt_q     <= '0;
            drain_cnt_q    <= '0;
            window_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rows_q         <= rows_d;
            fill_cnt_q     <= fill_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            window_valid_q <= window_valid_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state: mode exit beats drain, drain beats the fill-complete write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (mode_on) state_d = FILL;
            FILL: begin
                if (!mode_on)                  state_d = IDLE;
                else if (drain_req)            state_d = DRAIN;
                else if (buffer_we && fill_last) state_d = STREAM;
            end
            STREAM: begin
                if (!mode_on)       state_d = IDLE;
                else if (drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!mode_on || drain_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: row shifting, fill/drain counters and registered flags.
    always_comb begin
        rows_d         = rows_q;
        fill_cnt_d     = fill_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        window_valid_d = window_valid_q;
        case (state_q)
            FILL: begin
                if (drain_req) begin
                    drain_cnt_d = '0;
                end else if (buffer_we) begin
                    rows_d     = {rows_q[DEPTH-2:0], img_data};
                    fill_cnt_d = fill_cnt_q + CNT_W'(1);
                    if (fill_last) window_valid_d = 1'b1;
                end
            end
            STREAM: begin
                // A write coinciding with drain_req is still taken.
                if (buffer_we) rows_d = {rows_q[DEPTH-2:0], img_data};
                if (drain_req) drain_cnt_d = '0;
            end
            DRAIN: begin
                rows_d      = {rows_q[DEPTH-2:0], pad_row};
                drain_cnt_d = drain_cnt_q + CNT_W'(1);
                if (drain_last) begin
                    drain_cnt_d    = '0;
                    fill_cnt_d     = '0;
                    window_valid_d = 1'b0;
                end
            end
            default: begin
                rows_d         = '0;
                fill_cnt_d     = '0;
                drain_cnt_d    = '0;
                window_valid_d = 1'b0;
            end
        endcase
        // Leaving the active mode clears everything on the way to IDLE.
        if (state_q != IDLE && !mode_on) begin
            rows_d         = '0;
            fill_cnt_d     = '0;
            drain_cnt_d    = '0;
            window_valid_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    assign buf_data     = rows_q;
    assign fill_cnt     = fill_cnt_q;
    assign window_valid = window_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_line_buffer_param.sv
// Scoreboard bench for line_buffer_param (ROW_W=8, DEPTH=4, HALO=2, mode 1).
// Each cycle's expected outputs are queued when inputs are driven and popped
// after the clock edge for comparison.
module tb_line_buffer_param;

    localparam int ROW_W = 8;
    localparam int DEPTH = 4;
    localparam int HALO  = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [2:0]             buffer_mode;
    logic                   buffer_we;
    logic [ROW_W-1:0]       img_data;
    logic                   drain_req;
    logic [DEPTH*ROW_W-1:0] buf_data;
    logic [CNT_W-1:0]       fill_cnt;
    logic                   window_valid;
    logic                   busy;

    typedef struct {
        logic [31:0]      bd;
        logic [CNT_W-1:0] fc;
        logic             wv;
        logic             by;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    line_buffer_param #(
        .ROW_W(ROW_W), .DEPTH(DEPTH), .HALO(HALO), .ACTIVE_MODE(3'd1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .buffer_mode(buffer_mode),
        .buffer_we(buffer_we), .img_data(img_data), .drain_req(drain_req),
        .buf_data(buf_data), .fill_cnt(fill_cnt),
        .window_valid(window_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic step(input string tag, input logic rn, input logic [2:0] md,
                        input logic we, input logic [7:0] d, input logic dr,
                        input logic [31:0] eb, input logic [CNT_W-1:0] ef,
                        input logic ew, input logic ey);
        exp_t e;
        rst_n = rn; buffer_mode = md; buffer_we = we; img_data = d; drain_req = dr;
        e.bd = eb; e.fc = ef; e.wv = ew; e.by = ey;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".buf"},   buf_data,             e.bd);
        chk({tag, ".fill"},  32'(fill_cnt),        32'(e.fc));
        chk({tag, ".wv"},    32'(window_valid),    32'(e.wv));
        chk({tag, ".busy"},  32'(busy),            32'(e.by));
    endtask

`ifdef LB_BORDER_REPLICATE_EN
    localparam logic [31:0] S2_P1 = 32'h33445555, S2_P2 = 32'h44555555;
    localparam logic [31:0] S4_P1 = 32'hA2B1B2B2;
    localparam logic [31:0] S6_P1 = 32'h00000707, S6_P2 = 32'h00070707;
`else
    localparam logic [31:0] S2_P1 = 32'h33445500, S2_P2 = 32'h44550000;
    localparam logic [31:0] S4_P1 = 32'hA2B1B200;
    localparam logic [31:0] S6_P1 = 32'h00000700, S6_P2 = 32'h00070000;
`endif

    initial begin
        rst_n = 1'b0; buffer_mode = 3'd0; buffer_we = 1'b0; img_data = '0; drain_req = 1'b0;
        #2;
        //      tag       rn md   we d      dr  buf           fill wv by
        step("reset",   0, 3'd0, 1, 8'hFF, 1, 32'h00000000, 0, 0, 0);
        // Fill four rows, window becomes valid after the fourth.
        step("s1.enter", 1, 3'd1, 0, 8'h00, 0, 32'h00000000, 0, 0, 1);
        step("s1.w1",   1, 3'd1, 1, 8'h11, 0, 32'h00000011, 1, 0, 1);
        step("s1.w2",   1, 3'd1, 1, 8'h22, 0, 32'h00001122, 2, 0, 1);
        step("s1.w3",   1, 3'd1, 1, 8'h33, 0, 32'h00112233, 3, 0, 1);
        step("s1.w4",   1, 3'd1, 1, 8'h44, 0, 32'h11223344, 4, 1, 1);
        // Write plus drain together, then HALO pad rows, then one IDLE cycle.
        step("s2.wd",   1, 3'd1, 1, 8'h55, 1, 32'h22334455, 4, 1, 1);
        step("s2.p1",   1, 3'd1, 1, 8'hEE, 0, S2_P1,        4, 1, 1);
        step("s2.p2",   1, 3'd1, 0, 8'h00, 0, S2_P2,        0, 0, 0);
        step("s2.refill", 1, 3'd1, 1, 8'hEE, 0, 32'h00000000, 0, 0, 1);
        // Gaps in the write strobe hold the rows.
        step("s3.w1",   1, 3'd1, 1, 8'hA1, 0, 32'h000000A1, 1, 0, 1);
        step("s3.gap1", 1, 3'd1, 0, 8'hFF, 0, 32'h000000A1, 1, 0, 1);
        step("s3.gap2", 1, 3'd1, 0, 8'hFF, 0, 32'h000000A1, 1, 0, 1);
        step("s3.w2",   1, 3'd1, 1, 8'hA2, 0, 32'h0000A1A2, 2, 0, 1);
        step("s3.w3",   1, 3'd1, 1, 8'hB1, 0, 32'h00A1A2B1, 3, 0, 1);
        step("s3.w4",   1, 3'd1, 1, 8'hB2, 0, 32'hA1A2B1B2, 4, 1, 1);
        // Drain aborted by a mode change after one pad row.
        step("s4.dreq", 1, 3'd1, 0, 8'h00, 1, 32'hA1A2B1B2, 4, 1, 1);
        step("s4.p1",   1, 3'd1, 0, 8'h00, 0, S4_P1,        4, 1, 1);
        step("s4.exit", 1, 3'd2, 0, 8'h00, 0, 32'h00000000, 0, 0, 0);
        step("s4.idle", 1, 3'd2, 1, 8'hFF, 1, 32'h00000000, 0, 0, 0);
        // Reset in the middle of FILL.
        step("s5.enter", 1, 3'd1, 0, 8'h00, 0, 32'h00000000, 0, 0, 1);
        step("s5.w1",   1, 3'd1, 1, 8'h01, 0, 32'h00000001, 1, 0, 1);
        step("s5.w2",   1, 3'd1, 1, 8'h02, 0, 32'h00000102, 2, 0, 1);
        step("s5.w3",   1, 3'd1, 1, 8'h03, 0, 32'h00010203, 3, 0, 1);
        step("s5.rst",  0, 3'd1, 1, 8'h04, 0, 32'h00000000, 0, 0, 0);
        step("s5.enter", 1, 3'd1, 0, 8'h00, 0, 32'h00000000, 0, 0, 1);
        step("s5.w1b",  1, 3'd1, 1, 8'h07, 0, 32'h00000007, 1, 0, 1);
        // Drain straight from a partial FILL keeps window_valid low.
        step("s6.dreq", 1, 3'd1, 1, 8'hEE, 1, 32'h00000007, 1, 0, 1);
        step("s6.p1",   1, 3'd1, 1, 8'hEE, 0, S6_P1,        1, 0, 1);
        step("s6.p2",   1, 3'd1, 1, 8'hEE, 0, S6_P2,        0, 0, 0);
        // Mode exit from FILL.
        step("s7.enter", 1, 3'd1, 0, 8'h00, 0, 32'h00000000, 0, 0, 1);
        step("s7.w1",   1, 3'd1, 1, 8'h09, 0, 32'h00000009, 1, 0, 1);
        step("s7.exit", 1, 3'd0, 1, 8'h0A, 0, 32'h00000000, 0, 0, 0);
        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_param.md
Name: line_buffer_param

Overview:
- Parametrised line buffer for the window-based stages (Gaussian, keypoint detect) between image SRAM and the working modules.
- Holds DEPTH rows of ROW_W bits as a row shift register.
- Adds fill tracking, a window-valid flag and a drain phase that pads the bottom border with HALO synthetic rows.
- Configurable so that one block serves every stage in place of fixed 10-row buffers.

Parameters:
ROW_W  5120  bits per image row (one SRAM word)
DEPTH  10  rows held; legal range 2..16
HALO  5  rows shifted in during drain; legal range 1..DEPTH
ACTIVE_MODE  1  buffer_mode value that enables this instance (1 = SYS_GAUSSIAN)
CNT_W  $clog2(DEPTH+1)  width of fill_cnt

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
buffer_mode  in  3  system mode from controller
buffer_we  in  1  row write strobe; img_data valid this cycle
img_data  in  ROW_W  incoming row from SRAM
drain_req  in  1  single-cycle pulse: no more rows, begin bottom padding
buf_data  out  DEPTH*ROW_W  flattened rows; row k at [k*ROW_W +: ROW_W]; row 0 is newest
fill_cnt  out  CNT_W  number of real rows loaded, saturates at DEPTH
window_valid  out  1  high while all DEPTH rows are meaningful
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge): every row is 0; fill_cnt=0; window_valid=0; busy=0; state=IDLE; drain counter=0.
- Shift operation: row0 <= new row; row k <= row k-1 for k=1..DEPTH-1; row DEPTH-1 is discarded. Data appears on buf_data one cycle after the strobe.
- Priority, highest first: reset, then mode exit, then drain, then write.
- State IDLE:
  - Rows and fill_cnt are forced to 0 every cycle.
  - buffer_we and drain_req are ignored.
  - Goes to FILL the cycle after buffer_mode==ACTIVE_MODE.
- State FILL:
  - buffer_we=1: shift img_data in and increment fill_cnt.
  - buffer_we=0: hold all rows (no zero insertion).
  - Go to STREAM on the write that makes fill_cnt reach DEPTH; window_valid=1 from the next cycle.
  - drain_req in FILL goes to DRAIN; fill_cnt keeps its partial value.
- State STREAM:
  - buffer_we=1 shifts a row; fill_cnt holds DEPTH; window_valid=1.
  - drain_req goes to DRAIN next cycle.
  - If buffer_we and drain_req arrive together, the row is accepted first, then drain starts.
- State DRAIN:
  - Shifts a zero row every cycle, independent of buffer_we. Incoming writes are dropped.
  - The drain counter counts 0..HALO-1. After exactly HALO shifts, go to IDLE.
  - window_valid stays at its value from entry to DRAIN (1 from STREAM, 0 from FILL) until the IDLE transition.
- Mode exit:
  - buffer_mode != ACTIVE_MODE in FILL, STREAM or DRAIN goes to IDLE next cycle. This aborts any drain in progress.
  - window_valid, busy and fill_cnt are 0 starting that same next cycle; rows are cleared.
- Mode held at ACTIVE_MODE when returning to IDLE from DRAIN: re-enters FILL after one IDLE cycle, so contents are guaranteed cleared between frames.
- busy = (state != IDLE), registered with state.
- Reset mid-operation: full return to reset values on that edge.
- Out-of-range DEPTH or HALO: stop with a $error at elaboration.

Optional Feature:
- Macro: LB_BORDER_REPLICATE_EN.
- Defined: DRAIN shifts a copy of the current row0 instead of zero, giving edge replication for Gaussian borders. If DRAIN is entered with fill_cnt=0, zeros are shifted.
- Undefined: zero padding as above.
- All other behaviour is identical either way.

Test Plan:
(All scenarios use ROW_W=8, DEPTH=4, HALO=2, ACTIVE_MODE=1.)
1. Reset, mode=1, then writes 0x11,0x22,0x33,0x44 on consecutive cycles -> fill_cnt 1,2,3,4; buf_data rows0..3 = 44,33,22,11; window_valid=1 the cycle after the 4th write.
2. STREAM, write 0x55 with drain_req in the same cycle -> rows 55,44,33,22, then 00,55,44,33, then 00,00,55,44; IDLE and busy=0 on the next cycle.
3. FILL with buffer_we toggling 1,0,0,1 (data 0xA1, 0xA2) -> rows hold across the idle cycles; fill_cnt=2; window_valid stays 0.
4. STREAM, then mode changes to 2 during DRAIN after 1 shift -> next cycle IDLE; all rows 0, fill_cnt=0, window_valid=0; the second pad row is never produced.
5. Pulse rst_n=0 during FILL with fill_cnt=3 -> all outputs 0 the next cycle; mode=1 held restarts FILL from fill_cnt=0.
6. LB_BORDER_REPLICATE_EN defined, rerun scenario 2 -> rows 55,55,44,33 then 55,55,55,44.
